// File: rtl/srx_scan_pkg.sv
// -----------------------------------------------------------------------------
// srx_scan_pkg
//   Shared definitions for the observation-receiver antenna/path scan logic:
//   the scan state encoding, the path_mode encodings and the path-type
//   constants that the downstream RF switch map also decodes.
//
//   Contents
//     scan_state_t    : IDLE / SETTLE / REQ
//     PATH_MODE_*     : path_mode input encodings
//     PATH_TYPE_*     : path_sel values (0 = DPD, 1 = VSWR)
//     first_path()    : first path visited on an antenna for a given mode
//     lowest_set()    : index of the lowest set bit of an 8-bit mask
// -----------------------------------------------------------------------------
package srx_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_REQ    = 2'd2
  } scan_state_t;

  // path_mode encodings
  localparam logic [1:0] PATH_MODE_DPD  = 2'd0;  // DPD path only
  localparam logic [1:0] PATH_MODE_VSWR = 2'd1;  // VSWR path only
  localparam logic [1:0] PATH_MODE_BOTH = 2'd2;  // DPD then VSWR per antenna
  localparam logic [1:0] PATH_MODE_RSVD = 2'd3;  // reserved, treated as DPD only

  // path_sel values, shared with the switch map
  localparam logic PATH_TYPE_DPD  = 1'b0;
  localparam logic PATH_TYPE_VSWR = 1'b1;

  // Only VSWR-only mode starts on the VSWR path; every other mode
  // (including the reserved one) starts on DPD.
  function automatic logic first_path(input logic [1:0] mode);
    return (mode == PATH_MODE_VSWR) ? PATH_TYPE_VSWR : PATH_TYPE_DPD;
  endfunction

  // Lowest set bit of the mask; returns 0 for an all-zero mask, which the
  // callers never use because they gate on a non-zero mask first.
  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    // Walking downwards lets the lowest set bit be the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/srx_ant_next_sel.sv
// -----------------------------------------------------------------------------
// srx_ant_next_sel
//   Combinational next-antenna search. Finds the next set mask bit strictly
//   above the current antenna; if there is none, wraps to the lowest set bit
//   and raises wrap. The current antenna does not need to be in the mask.
//
//   Parameters
//     NUM_ANT : number of antennas (1..8)
//   Ports
//     mask    in  [NUM_ANT-1:0] antenna participation mask
//     cur     in  [2:0]         current antenna
//     nxt     out [2:0]         next antenna to visit
//     wrap    out               search wrapped past the top of the mask
// -----------------------------------------------------------------------------
module srx_ant_next_sel #(
  parameter int NUM_ANT = 4
) (
  input  logic [NUM_ANT-1:0] mask,
  input  logic [2:0]         cur,
  output logic [2:0]         nxt,
  output logic               wrap
);

  logic [2:0] above_idx;
  logic       above_found;
  logic [2:0] low_idx;

  // NOTE: every variable written in a combinational block gets a default at
  // the top of the block, otherwise a path that skips the assignment holds
  // the old value and a latch is inferred.
  always_comb begin
    above_idx   = 3'd0;
    above_found = 1'b0;
    low_idx     = 3'd0;
    // Descending scan: the last hit written is the smallest qualifying index.
    for (int i = NUM_ANT - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx = 3'(i);
        if (i > int'(cur)) begin
          above_idx   = 3'(i);
          above_found = 1'b1;
        end
      end
    end
  end

  assign nxt  = above_found ? above_idx : low_idx;
  assign wrap = ~above_found;

endmodule

// File: rtl/srx_ant_scan_ctrl.sv
// -----------------------------------------------------------------------------
// srx_ant_scan_ctrl
//   Sequencer for the observation-receiver RF switch network. Walks the
//   enabled antennas and DPD/VSWR paths, waits a programmable settle time
//   after each switch change, then holds a level capture request until the
//   capture engine acknowledges it or the request times out.
//
//   Parameters
//     NUM_ANT     : number of antennas (1..8)
//     CNT_W       : width of the settle and timeout counters
//     ACK_TIMEOUT : REQ cycles without cap_ack before the step is abandoned
//   Ports
//     clk, rst_n       clock, asynchronous active-low reset
//     enable       in  run the scan while high
//     ant_mask     in  antenna participation mask
//     path_mode    in  0 DPD, 1 VSWR, 2 DPD then VSWR, 3 as 0
//     settle_cycles in switch settle time (0 behaves as 1)
//     ant_sel      out antenna select to the switch map
//     path_sel     out path select to the switch map (0 DPD, 1 VSWR)
//     cap_req      out capture request, level-held
//     cap_ack      in  capture acknowledge, looked at only in REQ
//     cap_ant      out request tag, equals ant_sel
//     cap_path     out request tag, equals path_sel
//     busy         out state is not IDLE
//     scan_done    out 1-cycle pulse at the end of a full pass
//     timeout_err  out 1-cycle pulse when a request times out
// -----------------------------------------------------------------------------
module srx_ant_scan_ctrl
  import srx_scan_pkg::*;
#(
  parameter int NUM_ANT     = 4,
  parameter int CNT_W       = 16,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_ANT-1:0] ant_mask,
  input  logic [1:0]         path_mode,
  input  logic [CNT_W-1:0]   settle_cycles,
  output logic [2:0]         ant_sel,
  output logic               path_sel,
  output logic               cap_req,
  input  logic               cap_ack,
  output logic [2:0]         cap_ant,
  output logic               cap_path,
  output logic               busy,
  output logic               scan_done,
  output logic               timeout_err
);

  // The timeout counter holds the number of REQ edges already spent; the
  // step is abandoned on the edge that would make it ACK_TIMEOUT.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]       ant_q, ant_d;
  logic             path_q, path_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_err_q, tmo_err_d;

  logic             mask_any;
  logic [CNT_W-1:0] settle_last;
  logic             tmo_hit;
  logic             step_end;
  logic [2:0]       next_ant;
  logic             next_wrap;

  srx_ant_next_sel #(
    .NUM_ANT (NUM_ANT)
  ) u_next_sel (
    .mask (ant_mask),
    .cur  (ant_q),
    .nxt  (next_ant),
    .wrap (next_wrap)
  );

  assign mask_any = |ant_mask;

  // A zero settle time still spends one cycle in SETTLE. The counter starts
  // at 0 on entry, so SETTLE ends on the edge where it has reached S-1.
  assign settle_last = (settle_cycles == '0) ? '0 : settle_cycles - CNT_W'(1);

  assign tmo_hit  = (tmo_cnt_q == TMO_LAST);
  assign step_end = cap_ack | tmo_hit;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    ant_d        = ant_q;
    path_d       = path_q;
    done_d       = 1'b0;
    tmo_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && mask_any) begin
          state_d      = ST_SETTLE;
          ant_d        = lowest_set(8'(ant_mask));
          path_d       = first_path(path_mode);
          settle_cnt_d = '0;
        end
      end

      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (settle_cnt_q >= settle_last) begin
          // >= rather than == so a shortened settle_cycles mid-step
          // still terminates.
          state_d   = ST_REQ;
          tmo_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end

      ST_REQ: begin
        // enable is ignored until the handshake completes so an
        // outstanding request is never dropped.
        if (step_end) begin
          // An ack in the timeout cycle wins: no error pulse.
          tmo_err_d = ~cap_ack;
          if (enable && mask_any) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            if (path_mode == PATH_MODE_BOTH && path_q == PATH_TYPE_DPD) begin
              path_d = PATH_TYPE_VSWR;
            end else begin
              ant_d  = next_ant;
              path_d = first_path(path_mode);
              done_d = next_wrap;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Request and busy are registered from the next state so every output
  // comes straight off a flop.
  assign req_d  = (state_d == ST_REQ);
  assign busy_d = (state_d != ST_IDLE);

  // NOTE: sequential state is written with non-blocking assignments so all
  // flops update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      ant_q        <= 3'd0;
      path_q       <= PATH_TYPE_DPD;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ant_q        <= ant_d;
      path_q       <= path_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign ant_sel     = ant_q;
  assign path_sel    = path_q;
  assign cap_ant     = ant_q;
  assign cap_path    = path_q;
  assign cap_req     = req_q;
  assign busy        = busy_q;
  assign scan_done   = done_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_srx_ant_scan_ctrl.sv
`timescale 1ns/1ps
module tb_srx_ant_scan_ctrl;

  localparam int NUM_ANT = 4;
  localparam int CNT_W   = 16;
  localparam int TMO     = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic [NUM_ANT-1:0] ant_mask = '0;
  logic [1:0]         path_mode = 2'd0;
  logic [CNT_W-1:0]   settle_cycles = '0;
  logic [2:0]         ant_sel;
  logic               path_sel;
  logic               cap_req;
  logic               cap_ack = 1'b0;
  logic [2:0]         cap_ant;
  logic               cap_path;
  logic               busy;
  logic               scan_done;
  logic               timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  srx_ant_scan_ctrl #(
    .NUM_ANT     (NUM_ANT),
    .CNT_W       (CNT_W),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .ant_mask      (ant_mask),
    .path_mode     (path_mode),
    .settle_cycles (settle_cycles),
    .ant_sel       (ant_sel),
    .path_sel      (path_sel),
    .cap_req       (cap_req),
    .cap_ack       (cap_ack),
    .cap_ant       (cap_ant),
    .cap_path      (cap_path),
    .busy          (busy),
    .scan_done     (scan_done),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One scan step, entered at the falling edge right after the edge that
  // loaded the position. a = REQ edge at which cap_ack is sampled (a > TMO
  // means never acknowledged). Returns at the falling edge after step end.
  task automatic run_step(input string tag, input logic [2:0] e_ant, input logic e_path,
                          input int s, input int a, input bit early,
                          input bit e_done, input bit chk_done, input bit e_tmo,
                          input bit drop_en);
    int s_eff;
    int n;
    int lim;
    s_eff = (s == 0) ? 1 : s;
    check({tag, " ant_sel"}, 32'(ant_sel), 32'(e_ant));
    check({tag, " path_sel"}, 32'(path_sel), 32'(e_path));
    check({tag, " cap_ant"}, 32'(cap_ant), 32'(e_ant));
    check({tag, " cap_path"}, 32'(cap_path), 32'(e_path));
    check({tag, " req_low_in_settle"}, 32'(cap_req), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd1);
    // An ack outside REQ must have no effect on the settle count.
    if (early) cap_ack = 1'b1;
    n = 0;
    while (cap_req !== 1'b1 && n < s_eff + 20) begin
      @(negedge clk);
      n++;
    end
    cap_ack = 1'b0;
    check({tag, " settle_len"}, 32'(n), 32'(s_eff));
    if (drop_en) enable = 1'b0;
    lim = (a < TMO) ? a : TMO;
    for (int c = 1; c <= lim; c++) begin
      check($sformatf("%s req_held c%0d", tag, c), 32'(cap_req), 32'd1);
      if (c == a) cap_ack = 1'b1;
      @(negedge clk);
      cap_ack = 1'b0;
    end
    check({tag, " req_low_after"}, 32'(cap_req), 32'd0);
    check({tag, " timeout_err"}, 32'(timeout_err), 32'(e_tmo));
    if (chk_done) check({tag, " scan_done"}, 32'(scan_done), 32'(e_done));
    check({tag, " busy_after"}, 32'(busy), drop_en ? 32'd0 : 32'd1);
  endtask

  typedef struct {
    bit         first;
    bit         last;
    logic [3:0] mask;
    logic [1:0] mode;
    int         settle;
    int         ack_at;
    bit         early;
    logic [2:0] e_ant;
    logic       e_path;
    bit         e_done;
    bit         e_tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit first, input bit last, input logic [3:0] mask,
                     input logic [1:0] mode, input int settle, input int ack_at,
                     input bit early, input logic [2:0] e_ant, input logic e_path,
                     input bit e_done, input bit e_tmo);
    vec_t v;
    v.first = first; v.last = last; v.mask = mask; v.mode = mode;
    v.settle = settle; v.ack_at = ack_at; v.early = early;
    v.e_ant = e_ant; v.e_path = e_path; v.e_done = e_done; v.e_tmo = e_tmo;
    vecs.push_back(v);
  endtask

  typedef struct {
    logic [2:0] ant;
    logic       path;
  } pos_t;

  initial begin
    pos_t       order[$];
    pos_t       p;
    int         n;
    int         len;
    int         nsteps;
    int         a;
    logic [3:0] rmask;
    logic [1:0] rmode;
    int         rsettle;

    // ---------------- reset values ----------------
    #12;
    check("rst ant_sel", 32'(ant_sel), 0);
    check("rst path_sel", 32'(path_sel), 0);
    check("rst cap_req", 32'(cap_req), 0);
    check("rst busy", 32'(busy), 0);
    check("rst scan_done", 32'(scan_done), 0);
    check("rst timeout_err", 32'(timeout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- directed table ----------------
    //   first last mask    mode settle ack early ant path done tmo
    add(1, 0, 4'b1111, 2'd0, 10, 3, 0, 3'd0, 1'b0, 0, 0);
    add(0, 0, 4'b1111, 2'd0, 10, 3, 0, 3'd1, 1'b0, 0, 0);
    add(0, 0, 4'b1111, 2'd0, 10, 3, 0, 3'd2, 1'b0, 0, 0);
    add(0, 0, 4'b1111, 2'd0, 10, 3, 0, 3'd3, 1'b0, 1, 0);
    add(0, 1, 4'b1111, 2'd0, 10, 3, 0, 3'd0, 1'b0, 0, 0);
    add(1, 0, 4'b1010, 2'd2,  0, 1, 0, 3'd1, 1'b0, 0, 0);
    add(0, 0, 4'b1010, 2'd2,  0, 1, 0, 3'd1, 1'b1, 0, 0);
    add(0, 0, 4'b1010, 2'd2,  0, 1, 0, 3'd3, 1'b0, 0, 0);
    add(0, 0, 4'b1010, 2'd2,  0, 1, 0, 3'd3, 1'b1, 1, 0);
    add(0, 1, 4'b1010, 2'd2,  0, 1, 0, 3'd1, 1'b0, 0, 0);
    add(1, 0, 4'b0110, 2'd1,  2, 20, 0, 3'd1, 1'b1, 0, 1);
    add(0, 0, 4'b0110, 2'd1,  2, 20, 0, 3'd2, 1'b1, 1, 1);
    add(0, 1, 4'b0110, 2'd1,  2, 8, 0, 3'd1, 1'b1, 0, 0);
    add(1, 0, 4'b1001, 2'd0,  1, 2, 0, 3'd0, 1'b0, 0, 0);
    add(0, 0, 4'b0101, 2'd0,  1, 2, 0, 3'd3, 1'b0, 1, 0);
    add(0, 0, 4'b0101, 2'd0,  1, 2, 0, 3'd0, 1'b0, 0, 0);
    add(0, 1, 4'b0101, 2'd0,  1, 5, 0, 3'd2, 1'b0, 0, 0);
    add(1, 0, 4'b0100, 2'd2,  3, 4, 0, 3'd2, 1'b0, 0, 0);
    add(0, 0, 4'b0100, 2'd2,  3, 4, 0, 3'd2, 1'b1, 1, 0);
    add(0, 1, 4'b0100, 2'd2,  3, 4, 0, 3'd2, 1'b0, 0, 0);
    add(1, 0, 4'b0011, 2'd3,  1, 1, 1, 3'd0, 1'b0, 0, 0);
    add(0, 0, 4'b0011, 2'd3,  1, 1, 1, 3'd1, 1'b0, 1, 0);
    add(0, 1, 4'b0011, 2'd3,  1, 1, 1, 3'd0, 1'b0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      ant_mask      = vecs[i].mask;
      path_mode     = vecs[i].mode;
      settle_cycles = CNT_W'(vecs[i].settle);
      if (vecs[i].first) begin
        enable = 1'b1;
        @(negedge clk);
      end
      run_step($sformatf("vec%0d", i), vecs[i].e_ant, vecs[i].e_path, vecs[i].settle,
               vecs[i].ack_at, vecs[i].early, vecs[i].e_done, !vecs[i].last,
               vecs[i].e_tmo, vecs[i].last);
    end

    // ---------------- enable dropped in SETTLE ----------------
    ant_mask = 4'b1111; path_mode = 2'd0; settle_cycles = CNT_W'(5);
    enable = 1'b1;
    @(negedge clk);
    check("drop_settle busy_before", 32'(busy), 1);
    enable = 1'b0;
    @(negedge clk);
    check("drop_settle busy_after", 32'(busy), 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (cap_req !== 1'b0) n++;
      @(negedge clk);
    end
    check("drop_settle no_request", 32'(n), 0);

    // ---------------- zero mask stays idle ----------------
    ant_mask = 4'b0000;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("mask0 busy", 32'(busy), 0);
    check("mask0 cap_req", 32'(cap_req), 0);
    enable = 1'b0;
    @(negedge clk);

    // ---------------- async reset in REQ ----------------
    ant_mask = 4'b0100; path_mode = 2'd1; settle_cycles = CNT_W'(1);
    enable = 1'b1;
    n = 0;
    while (cap_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("arst reached_req", 32'(cap_req), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst ant_sel", 32'(ant_sel), 0);
    check("arst path_sel", 32'(path_sel), 0);
    check("arst cap_ant", 32'(cap_ant), 0);
    check("arst cap_path", 32'(cap_path), 0);
    check("arst cap_req", 32'(cap_req), 0);
    check("arst busy", 32'(busy), 0);
    check("arst scan_done", 32'(scan_done), 0);
    check("arst timeout_err", 32'(timeout_err), 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- randomized runs against a pass-order model ----------------
    for (int r = 0; r < 8; r++) begin
      rmask   = 4'($urandom_range(1, 15));
      rmode   = 2'($urandom_range(0, 3));
      rsettle = $urandom_range(0, 4);
      order.delete();
      for (int ant = 0; ant < NUM_ANT; ant++) begin
        if (rmask[ant]) begin
          p.ant = 3'(ant);
          if (rmode == 2'd1) begin
            p.path = 1'b1; order.push_back(p);
          end else if (rmode == 2'd2) begin
            p.path = 1'b0; order.push_back(p);
            p.path = 1'b1; order.push_back(p);
          end else begin
            p.path = 1'b0; order.push_back(p);
          end
        end
      end
      len    = order.size();
      nsteps = 2 * len + 1;
      ant_mask = rmask; path_mode = rmode; settle_cycles = CNT_W'(rsettle);
      enable = 1'b1;
      @(negedge clk);
      for (int k = 0; k < nsteps; k++) begin
        a = $urandom_range(1, 11);
        run_step($sformatf("rnd%0d.%0d", r, k), order[k % len].ant, order[k % len].path,
                 rsettle, a, bit'($urandom_range(0, 1)), (k % len) == len - 1,
                 k != nsteps - 1, a > TMO, k == nsteps - 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
